// File: rtl/serial_cmd_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : serial_cmd_pkg
//  Description : Shared definitions for the serial command path (collector
//                and decoder): FSM state encoding, default framing bytes and
//                the depth of the shared byte fifo.
//  Revision    : 1.0 - initial release
// ============================================================================
package serial_cmd_pkg;

   // Collector FSM state encoding
   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,
      ST_COLLECT = 3'd1,
      ST_READY   = 3'd2,
      ST_ACK     = 3'd3,
      ST_FLUSH   = 3'd4
   } state_t;

   // Framing markers, also used by serial_cmd_decoder
   localparam logic [7:0] DEFAULT_SOF_BYTE = 8'hFF;
   localparam logic [7:0] DEFAULT_EOF_BYTE = 8'hEE;

   // Depth of the shared byte fifo; a frame must fit in it completely
   localparam int FIFO_DEPTH = 16;

endpackage
`default_nettype wire

// File: rtl/serial_cmd_timeout.sv
`default_nettype none
// ============================================================================
//  Module      : serial_cmd_timeout
//  Description : Loadable 23-bit inter-byte watchdog. The counter is cleared
//                by i_restart, counts while i_enable is high and saturates at
//                all-ones. o_expired flags that the count has reached
//                TIMEOUT_CYCLES-1 while enabled.
//  Revision    : 1.0 - initial release
//
//  Ports:
//    clk        in   system clock
//    rst        in   asynchronous active-high reset
//    i_restart  in   load counter with zero (has priority over i_enable)
//    i_enable   in   count this cycle
//    o_expired  out  counter reached TIMEOUT_CYCLES-1 while enabled
// ============================================================================
module serial_cmd_timeout #(
   parameter int TIMEOUT_CYCLES = 5000000
) (
   input  logic clk,
   input  logic rst,
   input  logic i_restart,
   input  logic i_enable,
   output logic o_expired
);

   localparam logic [22:0] c_limit = 23'(TIMEOUT_CYCLES - 1);
   localparam logic [22:0] c_sat   = 23'h7F_FFFF;

   logic [22:0] r_timer;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_timer <= '0;
      end else if (i_restart) begin
         r_timer <= '0;
      end else if (i_enable && (r_timer != c_sat)) begin
         r_timer <= r_timer + 23'd1;
      end
   end

   // Greater-or-equal keeps the flag up once saturated
   assign o_expired = i_enable && (r_timer >= c_limit);

endmodule
`default_nettype wire

// File: rtl/serial_cmd_collector.sv
`default_nettype none
// ============================================================================
//  Module      : serial_cmd_collector
//  Description : Framing stage between the UART receiver and the shared byte
//                fifo. Hunts for SOF, pushes the frame up to and including
//                EOF, raises o_cmd_ready, runs the processed/received
//                handshake with the decoder and clears the fifo after bad,
//                overlong, timed-out or partially consumed frames.
//  Revision    : 1.0 - initial release
//
//  Ports:
//    clk, rst                     clock / asynchronous active-high reset
//    i_rx_data, i_rx_valid        byte stream from the UART receiver
//    o_fifo_push, o_fifo_data     registered push into the fifo
//    o_fifo_clear                 one-cycle fifo clear
//    o_cmd_ready                  complete frame waiting in the fifo
//    i_cmd_processed              decoder finished with the frame
//    i_cmd_bytes_processed        bytes the decoder popped
//    i_cmd_decode_success         decoder verdict
//    o_cmd_processed_received     acknowledge to the decoder
//    o_cmd_bytes                  length of the current / last frame
//    o_last_decode_ok             verdict latched for the last frame
//    o_err_overflow/o_err_timeout sticky error flags
//    o_frame_count                frames handed to the decoder
// ============================================================================
module serial_cmd_collector
   import serial_cmd_pkg::*;
#(
   parameter logic [7:0] SOF_BYTE       = DEFAULT_SOF_BYTE,
   parameter logic [7:0] EOF_BYTE       = DEFAULT_EOF_BYTE,
   parameter int         MAX_CMD_BYTES  = FIFO_DEPTH,
   parameter int         TIMEOUT_CYCLES = 5000000
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [7:0]  i_rx_data,
   input  logic        i_rx_valid,
   output logic        o_fifo_push,
   output logic [7:0]  o_fifo_data,
   output logic        o_fifo_clear,
   output logic        o_cmd_ready,
   input  logic        i_cmd_processed,
   input  logic [7:0]  i_cmd_bytes_processed,
   input  logic        i_cmd_decode_success,
   output logic        o_cmd_processed_received,
   output logic [7:0]  o_cmd_bytes,
   output logic        o_last_decode_ok,
   output logic        o_err_overflow,
   output logic        o_err_timeout,
   output logic [15:0] o_frame_count
);

   // A non-EOF byte arriving while this many bytes are stored would make the
   // frame full without a terminator, so it is rejected.
   localparam logic [7:0] c_last_slot = 8'(MAX_CMD_BYTES - 1);

   state_t      r_state;
   state_t      w_next_state;

   logic        r_fifo_push;
   logic [7:0]  r_fifo_data;
   logic        r_cmd_ready;
   logic [7:0]  r_cmd_bytes;
   logic        r_last_ok;
   logic [7:0]  r_bytes_proc;
   logic        r_err_overflow;
   logic        r_err_timeout;
   logic [15:0] r_frame_count;

   logic        w_push;
   logic        w_first;
   logic        w_count;
   logic        w_set_ovf;
   logic        w_set_to;
   logic        w_latch;
   logic        w_clear;
   logic        w_ack;
   logic        w_expired;
   logic        w_collecting;

   // ---------------------------------------------------------------------
   // Inter-byte watchdog: held at zero outside COLLECT and on every byte
   // ---------------------------------------------------------------------
   assign w_collecting = (r_state == ST_COLLECT);

   serial_cmd_timeout #(
      .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
   ) u_timeout (
      .clk       (clk),
      .rst       (rst),
      .i_restart (!w_collecting || i_rx_valid),
      .i_enable  (w_collecting),
      .o_expired (w_expired)
   );

   // ---------------------------------------------------------------------
   // FSM state register
   // ---------------------------------------------------------------------
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_next_state;
      end
   end

   // ---------------------------------------------------------------------
   // FSM next state and control strobes
   // ---------------------------------------------------------------------
   always_comb begin
      w_next_state = r_state;
      w_push       = 1'b0;
      w_first      = 1'b0;
      w_count      = 1'b0;
      w_set_ovf    = 1'b0;
      w_set_to     = 1'b0;
      w_latch      = 1'b0;
      w_clear      = 1'b0;
      w_ack        = 1'b0;

      case (r_state)
         ST_IDLE: begin
            if (i_rx_valid && (i_rx_data == SOF_BYTE)) begin
               w_push       = 1'b1;
               w_first      = 1'b1;
               w_next_state = ST_COLLECT;
            end
         end

         ST_COLLECT: begin
            // A byte arriving on the expiry cycle still counts as in time
            if (i_rx_valid) begin
               if (i_rx_data == EOF_BYTE) begin
                  w_push       = 1'b1;
                  w_count      = 1'b1;
                  w_next_state = ST_READY;
               end else if (r_cmd_bytes == c_last_slot) begin
                  w_set_ovf    = 1'b1;
                  w_next_state = ST_FLUSH;
               end else begin
                  w_push  = 1'b1;
                  w_count = 1'b1;
               end
            end else if (w_expired) begin
               w_set_to     = 1'b1;
               w_next_state = ST_FLUSH;
            end
         end

         ST_READY: begin
            if (i_cmd_processed) begin
               w_latch      = 1'b1;
               w_next_state = ST_ACK;
            end
         end

         ST_ACK: begin
            w_ack = 1'b1;
            if (!i_cmd_processed) begin
               // Leftover bytes in the fifo or a rejected frame force a clear
               if (!r_last_ok || (r_bytes_proc != r_cmd_bytes)) begin
                  w_next_state = ST_FLUSH;
               end else begin
                  w_next_state = ST_IDLE;
               end
            end
         end

         ST_FLUSH: begin
            w_clear      = 1'b1;
            w_next_state = ST_IDLE;
         end

         default: begin
            w_next_state = ST_IDLE;
         end
      endcase
   end

   // ---------------------------------------------------------------------
   // Datapath registers
   // ---------------------------------------------------------------------
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_fifo_push    <= 1'b0;
         r_fifo_data    <= '0;
         r_cmd_ready    <= 1'b0;
         r_cmd_bytes    <= '0;
         r_last_ok      <= 1'b0;
         r_bytes_proc   <= '0;
         r_err_overflow <= 1'b0;
         r_err_timeout  <= 1'b0;
         r_frame_count  <= '0;
      end else begin
         r_fifo_push <= w_push;
         if (w_push) begin
            r_fifo_data <= i_rx_data;
         end

         if (w_first) begin
            r_cmd_bytes <= 8'd1;
         end else if (w_count) begin
            r_cmd_bytes <= r_cmd_bytes + 8'd1;
         end else if (w_clear) begin
            r_cmd_bytes <= '0;
         end

         // Rises one cycle after entering READY, i.e. one cycle after the
         // EOF push, so the EOF byte is already in the fifo.
         r_cmd_ready <= (r_state == ST_READY) && (w_next_state == ST_READY);

         if (w_latch) begin
            r_last_ok     <= i_cmd_decode_success;
            r_bytes_proc  <= i_cmd_bytes_processed;
            r_frame_count <= r_frame_count + 16'd1;
         end

         if (w_set_ovf) begin
            r_err_overflow <= 1'b1;
         end
         if (w_set_to) begin
            r_err_timeout <= 1'b1;
         end
      end
   end

   assign o_fifo_push              = r_fifo_push;
   assign o_fifo_data              = r_fifo_data;
   assign o_fifo_clear             = w_clear;
   assign o_cmd_ready              = r_cmd_ready;
   assign o_cmd_processed_received = w_ack;
   assign o_cmd_bytes              = r_cmd_bytes;
   assign o_last_decode_ok         = r_last_ok;
   assign o_err_overflow           = r_err_overflow;
   assign o_err_timeout            = r_err_timeout;
   assign o_frame_count            = r_frame_count;

endmodule
`default_nettype wire
